// File: rtl/tl_a_arbiter_2to1_pkg.sv
// Shared TileLink-UL types, opcodes and beat math for the 2:1 A-channel arbiter.
// Used by every file of tl_a_arbiter_2to1 (perf option: TL_ARB_PERF_EN).
package tl_arb_pkg;

   localparam int SRC_W      = 3;
   localparam int BEAT_BYTES = 8;
   localparam int MAX_SIZE   = 6;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = BEAT_BYTES * 8;
   localparam int BEAT_LG    = $clog2(BEAT_BYTES);
   localparam int BEATS_W    = 8;

   localparam logic [2:0] PUT_FULL    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL = 3'd1;
   localparam logic [2:0] GET         = 3'd4;
   localparam logic [2:0] ACK         = 3'd0;
   localparam logic [2:0] ACK_DATA    = 3'd1;

   typedef struct packed {
      logic [2:0]            opcode;
      logic [2:0]            param;
      logic [2:0]            size;
      logic [SRC_W-1:0]      source;
      logic [ADDR_W-1:0]     address;
      logic [BEAT_BYTES-1:0] mask;
      logic [DATA_W-1:0]     data;
      logic                  corrupt;
   } tl_a_req_t;

   typedef struct packed {
      logic [2:0]            opcode;
      logic [2:0]            param;
      logic [2:0]            size;
      logic [SRC_W:0]        source;
      logic [ADDR_W-1:0]     address;
      logic [BEAT_BYTES-1:0] mask;
      logic [DATA_W-1:0]     data;
      logic                  corrupt;
   } tl_a_out_t;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [2:0]        size;
      logic [SRC_W-1:0]  source;
      logic              denied;
      logic [DATA_W-1:0] data;
      logic              corrupt;
   } tl_d_req_t;

   typedef struct packed {
      logic [2:0]        opcode;
      logic [2:0]        size;
      logic [SRC_W:0]    source;
      logic              denied;
      logic [DATA_W-1:0] data;
      logic              corrupt;
   } tl_d_out_t;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;

   // Only Puts carry data beats; anything up to one bus width is one beat.
   function automatic logic [BEATS_W-1:0] beats_of(
      input logic [2:0] opcode,
      input logic [2:0] size
   );
      logic [BEATS_W-1:0] b;
      b = BEATS_W'(1);
      if ((opcode == PUT_FULL || opcode == PUT_PARTIAL) &&
          size > 3'(BEAT_LG))
         b = BEATS_W'(1) << (size - 3'(BEAT_LG));
      return b;
   endfunction

endpackage

// File: rtl/tl_a_arbiter_2to1_if.sv
// Requester-side and memory-side TileLink-UL A/D handshake bundles.
// Part of tl_a_arbiter_2to1 (perf option: TL_ARB_PERF_EN).
interface tl_req_if;
   import tl_arb_pkg::*;

   logic      a_valid;
   logic      a_ready;
   tl_a_req_t a_bits;
   logic      d_valid;
   logic      d_ready;
   tl_d_req_t d_bits;

   modport master (
      output a_valid, a_bits, d_ready,
      input  a_ready, d_valid, d_bits
   );
   modport slave (
      input  a_valid, a_bits, d_ready,
      output a_ready, d_valid, d_bits
   );
endinterface

interface tl_mem_if;
   import tl_arb_pkg::*;

   logic      a_valid;
   logic      a_ready;
   tl_a_out_t a_bits;
   logic      d_valid;
   logic      d_ready;
   tl_d_out_t d_bits;

   modport master (
      output a_valid, a_bits, d_ready,
      input  a_ready, d_valid, d_bits
   );
   modport slave (
      input  a_valid, a_bits, d_ready,
      output a_ready, d_valid, d_bits
   );
endinterface

// File: rtl/tl_a_arbiter_2to1_beat_counter.sv
// Burst lock holder: owning requester index and remaining-beat down-counter.
// Part of tl_a_arbiter_2to1 (perf option: TL_ARB_PERF_EN).
module tl_beat_counter
   import tl_arb_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               load_idx,
   input  logic [BEATS_W-1:0] load_cnt,
   input  logic               dec,
   output logic               lock_idx,
   output logic               last
);

   logic [BEATS_W-1:0] beats_left;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_idx   <= 1'b0;
         beats_left <= '0;
      end else if (load) begin
         lock_idx   <= load_idx;
         beats_left <= load_cnt;
      end else if (dec && beats_left != '0) begin
         beats_left <= beats_left - 1'b1;
      end
   end

   assign last = (beats_left == BEATS_W'(1));

endmodule

// File: rtl/tl_a_arbiter_2to1.sv
// Round-robin 2:1 TileLink-UL A arbiter with burst lock and source-tagged D routing.
// Optional perf counters when TL_ARB_PERF_EN is defined.
module tl_a_arbiter_2to1
   import tl_arb_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   tl_req_if.slave  in0,
   tl_req_if.slave  in1,
   tl_mem_if.master out
`ifdef TL_ARB_PERF_EN
   ,
   output logic [31:0] perf_grants0,
   output logic [31:0] perf_grants1,
   output logic [31:0] perf_conflicts
`endif
);

   arb_state_t         state, state_n;
   logic               rr_ptr, rr_n;
   logic               g, g_valid, fire;
   tl_a_req_t          gb;
   logic [BEATS_W-1:0] beats;
   logic               load, dec, lock_idx, last;
   logic               dsel;

   always_comb begin
      g = 1'b0;
      if (state == LOCKED)
         g = lock_idx;
      else if (in0.a_valid && in1.a_valid)
         g = rr_ptr;
      else if (in1.a_valid)
         g = 1'b1;
   end

   assign g_valid = g ? in1.a_valid : in0.a_valid;
   assign gb      = g ? in1.a_bits  : in0.a_bits;
   assign beats   = beats_of(gb.opcode, gb.size);

   always_comb begin
      out.a_bits         = '0;
      out.a_bits.opcode  = gb.opcode;
      out.a_bits.param   = gb.param;
      out.a_bits.size    = gb.size;
      out.a_bits.source  = {g, gb.source};
      out.a_bits.address = gb.address;
      out.a_bits.mask    = gb.mask;
      out.a_bits.data    = gb.data;
      out.a_bits.corrupt = gb.corrupt;
   end

   // Reset gating keeps all handshakes quiet while reset is held.
   assign out.a_valid = g_valid & ~reset;
   assign in0.a_ready = ~reset & ~g & out.a_ready;
   assign in1.a_ready = ~reset &  g & out.a_ready;
   assign fire        = out.a_valid & out.a_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= 1'b0;
      end else begin
         state  <= state_n;
         rr_ptr <= rr_n;
      end
   end

   always_comb begin
      state_n = state;
      rr_n    = rr_ptr;
      load    = 1'b0;
      dec     = 1'b0;
      unique case (state)
         IDLE: begin
            if (fire) begin
               if (beats == BEATS_W'(1)) begin
                  rr_n = ~g;
               end else begin
                  load    = 1'b1;
                  state_n = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (fire) begin
               dec = 1'b1;
               if (last) begin
                  rr_n    = ~lock_idx;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   tl_beat_counter u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (load),
      .load_idx (g),
      .load_cnt (beats - BEATS_W'(1)),
      .dec      (dec),
      .lock_idx (lock_idx),
      .last     (last)
   );

   assign dsel = out.d_bits.source[SRC_W];

   always_comb begin
      in0.d_bits         = '0;
      in0.d_bits.opcode  = out.d_bits.opcode;
      in0.d_bits.size    = out.d_bits.size;
      in0.d_bits.source  = out.d_bits.source[SRC_W-1:0];
      in0.d_bits.denied  = out.d_bits.denied;
      in0.d_bits.data    = out.d_bits.data;
      in0.d_bits.corrupt = out.d_bits.corrupt;
      in1.d_bits         = in0.d_bits;
   end

   assign in0.d_valid = ~reset & out.d_valid & ~dsel;
   assign in1.d_valid = ~reset & out.d_valid &  dsel;
   assign out.d_ready = ~reset & (dsel ? in1.d_ready : in0.d_ready);

`ifdef TL_ARB_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_grants0   <= '0;
         perf_grants1   <= '0;
         perf_conflicts <= '0;
      end else begin
         if (state == IDLE && fire && !g)
            perf_grants0 <= perf_grants0 + 32'd1;
         if (state == IDLE && fire && g)
            perf_grants1 <= perf_grants1 + 32'd1;
         if (state == IDLE && in0.a_valid && in1.a_valid)
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

   a_size_legal: assert property (
      @(posedge clock) disable iff (reset)
      out.a_valid |-> (out.a_bits.size <= 3'(MAX_SIZE))
   );

endmodule

// File: doc/tl_a_arbiter_2to1.md
Name: tl_a_arbiter_2to1

Overview:
- Shares one TileLink-UL master port between two requesters, in0 and in1. The master port feeds the width-widget wrapper on the harness memory path.
- Arbitrates the A channel round-robin and holds the grant for the full length of a multi-beat Put burst.
- Tags the outgoing source with the requester index, then uses that tag to route D responses back to the right requester.
- Sits directly upstream of the widget wrapper's auto_widget_in_* port.

Parameters:
- SRC_W, 3: requester source-ID width. The output source is SRC_W+1 bits, so 4 bits by default, matching the widget.
- BEAT_BYTES, 8: A/D data-bus bytes per beat. Must be a power of 2.
- MAX_SIZE, 6: largest legal lg2(transfer bytes), 64B.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- in0_a_valid / in1_a_valid  in  1  requester A valid.
- in0_a_ready / in1_a_ready  out  1  requester A ready.
- in0_a_bits / in1_a_bits  in  tl_a_req_t  A fields: opcode, param, size, source[SRC_W], address, mask, data, corrupt.
- in0_d_valid / in1_d_valid  out  1  routed D valid.
- in0_d_ready / in1_d_ready  in  1  requester D ready.
- in0_d_bits / in1_d_bits  out  tl_d_req_t  D fields with source[SRC_W] (tag stripped).
- out_a_valid  out  1  to widget auto_widget_in_a_valid.
- out_a_ready  in  1  from widget.
- out_a_bits  out  tl_a_out_t  A fields with source[SRC_W+1]; MSB = requester index.
- out_d_valid  in  1  from widget.
- out_d_ready  out  1  to widget.
- out_d_bits  in  tl_d_out_t  D fields: opcode, size, source[SRC_W+1], denied, data, corrupt.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0 (in0 favoured), beats_left=0. out_a_valid=0, in*_a_ready=0, in*_d_valid=0, out_d_ready=0 while reset is asserted.
- States: IDLE, LOCKED.
- IDLE, grant selection (combinational, zero latency): exactly one requester valid -> it is granted. Both valid -> grant in[rr_ptr].
  - out_a_valid = granted valid; out_a_bits = granted bits with source = {idx, src}.
  - in[g]_a_ready = out_a_ready; the non-granted requester's ready = 0.
- Beat count: beats = (opcode is PutFull(0) or PutPartial(1)) ? max(1, 2^size / BEAT_BYTES) : 1.
- IDLE, on fire (out_a_valid & out_a_ready):
  - beats==1 -> rr_ptr <= ~g; stay in IDLE.
  - beats>1 -> lock_idx <= g, beats_left <= beats-1, go to LOCKED.
- LOCKED: only in[lock_idx] is connected; the other requester's ready = 0 even when its valid is high.
  - On each fire, beats_left decrements.
  - On the fire with beats_left==1 -> rr_ptr <= ~lock_idx; go to IDLE.
- Holding a grant while the requester's valid drops mid-burst is legal; the arbiter stays LOCKED with no timeout.
- D routing (combinational, no state):
  - in[k]_d_valid = out_d_valid & (out_d_bits.source[SRC_W]==k).
  - out_d_ready = in[source MSB]_d_ready.
  - in[k]_d_bits.source = source[SRC_W-1:0]; other fields pass through.
- D routing is independent of A state. A and D may fire in the same cycle.
- size > MAX_SIZE is illegal; behaviour is undefined and an assertion fires.
- Reset asserted mid-burst: everything returns to reset values immediately. The remaining beats are lost; the system is reset too.
- No combinational path from out_a_ready to out_a_valid.

Optional Feature:
- TL_ARB_PERF_EN defined: adds outputs perf_grants0 and perf_grants1 [31:0], plus perf_conflicts [31:0].
  - Grant counters count first-beat fires per requester.
  - perf_conflicts counts IDLE cycles where both requesters are valid.
  - All three counters wrap modulo 2^32 and reset to 0.
- TL_ARB_PERF_EN undefined: these ports and the counters are absent.

Decomposition:
- Package tl_arb_pkg holds:
  - the struct typedefs tl_a_req_t, tl_a_out_t, tl_d_req_t, tl_d_out_t;
  - opcode constants PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACK=0, ACK_DATA=1;
  - the function beats_of(opcode, size).
- One natural sub-module: tl_beat_counter, holding the lock and the beats_left down-counter with its last-beat flag.

Test Plan:
- Single requester: in0 sends Get (size 3, source 5) -> out source 4'b0101, granted in the same cycle. D with source 4'b0101 -> in0_d_valid=1, source 3'd5, in1_d_valid=0.
- Contention: both requesters send Gets every cycle with out_a_ready=1 -> grants alternate in0, in1, in0, in1, starting with in0 after reset.
- Burst lock: in1 sends PutFull size 6 (8 beats) while in0 is valid throughout -> 8 consecutive in1 fires with in0_a_ready=0. After the 8th beat, in0 is granted next.
- Backpressure: out_a_ready toggles 1,0,1,0 during a 4-beat burst (size 5) -> lock holds, beats_left reaches 0 only after the 4th accepted beat, and data order is preserved.
- D routing under stall: out_d source MSB=1 with in1_d_ready=0 -> out_d_ready=0 and in0_d_valid=0. The response is accepted once in1_d_ready=1.
- Reset mid-burst: assert reset after 3 of 8 beats -> out_a_valid=0 immediately. After release, rr_ptr=0 and state=IDLE.
